mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates word fetches from IF and 1/2/4-byte loads/stores
// from MEM onto a byte-wide RAM port, one byte per cycle, little-endian.
// MEM has priority. The port that receives done is masked for that cycle,
// so a request still held high is not served twice.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; low freezes the block
//   if_req/if_addr      fetch request (held until if_done)
//   if_flush            branch flush (used only with MEM_ARB_FLUSH_EN)
//   if_done/if_inst     one-cycle done pulse and fetched word
//   mem_req/we/len/addr/wdata   load/store request (held until mem_done)
//   mem_done/mem_rdata  one-cycle done pulse and zero-extended load data
//   ram_din             RAM read data for the address of the previous cycle
//   ram_dout/ram_a/ram_wr  RAM write data, address and write strobe
//
// Optional feature: define MEM_ARB_FLUSH_EN to let if_flush abort an
// in-flight fetch and mask if_req while idle.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [1:0]  state;
    logic        port;       // 1 = MEM, 0 = IF
    logic [31:0] base;
    logic [2:0]  n;
    logic [2:0]  icnt;
    logic [2:0]  rcnt;
    logic [31:0] buf_q;
    logic [31:0] last_a;     // ram_a holds this when nothing is issued
    logic        prev_iss;   // a read address went out last cycle
    logic        stall_q;    // last cycle had rdy low

    logic [2:0]  icnt_eff;
    logic        issue;
    logic        capture;
    logic        last_cap;
    logic [31:0] buf_nxt;
    logic [31:0] a_cur;
    logic [2:0]  len_n;
    logic        mem_ok;
    logic        if_ok;
    logic        flush_hit;
    logic        if_blocked;

`ifdef MEM_ARB_FLUSH_EN
    assign flush_hit  = rdy && (state == S_RD) && !port && if_flush;
    assign if_blocked = if_flush;
`else
    logic flush_unused;
    assign flush_unused = if_flush;
    assign flush_hit    = 1'b0;
    assign if_blocked   = 1'b0;
`endif

    always_comb begin
        // After a stall the byte that was in flight is lost, so reads
        // restart from the first byte not yet captured.
        icnt_eff = (state == S_RD && stall_q) ? rcnt : icnt;
        issue    = rdy && (((state == S_RD) && (icnt_eff < n)) || (state == S_WR));
        capture  = rdy && (state == S_RD) && prev_iss;
        last_cap = capture && (rcnt + 3'd1 == n);
        buf_nxt  = buf_q | ({24'h0, ram_din} << {rcnt[1:0], 3'b000});
        a_cur    = base + {29'h0, icnt_eff};
        len_n    = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
        mem_ok   = mem_req && !mem_done;
        if_ok    = if_req && !if_done && !if_blocked;
    end

    assign ram_a    = issue ? a_cur : last_a;
    assign ram_wr   = issue && (state == S_WR);
    assign ram_dout = ram_wr ? mem_wdata[{icnt[1:0], 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            port      <= 1'b0;
            base      <= '0;
            n         <= '0;
            icnt      <= '0;
            rcnt      <= '0;
            buf_q     <= '0;
            last_a    <= '0;
            prev_iss  <= 1'b0;
            stall_q   <= 1'b0;
            if_done   <= 1'b0;
            if_inst   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            stall_q  <= !rdy;
            prev_iss <= issue && (state == S_RD);
            if (issue) last_a <= a_cur;
            if (rdy) begin
                if_done  <= 1'b0;
                mem_done <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (mem_ok) begin
                            port  <= 1'b1;
                            base  <= mem_addr;
                            n     <= len_n;
                            icnt  <= '0;
                            rcnt  <= '0;
                            buf_q <= '0;
                            state <= mem_we ? S_WR : S_RD;
                        end else if (if_ok) begin
                            port  <= 1'b0;
                            base  <= if_addr;
                            n     <= 3'd4;
                            icnt  <= '0;
                            rcnt  <= '0;
                            buf_q <= '0;
                            state <= S_RD;
                        end
                    end
                    S_RD: begin
                        if (flush_hit) begin
                            state <= S_IDLE;
                        end else begin
                            icnt <= issue ? icnt_eff + 3'd1 : icnt_eff;
                            if (capture) begin
                                buf_q <= buf_nxt;
                                rcnt  <= rcnt + 3'd1;
                            end
                            if (last_cap) begin
                                state <= S_IDLE;
                                if (port) begin
                                    mem_done  <= 1'b1;
                                    mem_rdata <= buf_nxt;
                                end else begin
                                    if_done <= 1'b1;
                                    if_inst <= buf_nxt;
                                end
                            end
                        end
                    end
                    S_WR: begin
                        icnt <= icnt + 3'd1;
                        if (icnt + 3'd1 == n) begin
                            state    <= S_IDLE;
                            mem_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios with cycle checks,
// then randomized IF/MEM traffic with random rdy stalls. Expected results
// come from a byte-level RAM reference kept in the bench.
module tb_mem_arbiter;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, if_done;
    logic [31:0] if_addr = '0, if_inst;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_done;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [7:0]  ram_din = '0, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM seen by the DUT; unwritten bytes read as init_byte(address).
    logic [7:0] ram   [262144];
    bit         ram_v [262144];
    logic       poke_en = 1'b0;
    logic [17:0] poke_a = '0;
    logic [7:0]  poke_d = '0;

    function automatic logic [7:0] init_byte(input logic [17:0] i);
        int t;
        t = (int'(i) * 29) ^ (int'(i) >> 7) ^ 32'h5A;
        return t[7:0];
    endfunction

    always @(posedge clk) begin
        ram_din <= ram_v[ram_a[17:0]] ? ram[ram_a[17:0]] : init_byte(ram_a[17:0]);
        if (poke_en) begin ram[poke_a] <= poke_d; ram_v[poke_a] <= 1'b1; end
        if (ram_wr)  begin ram[ram_a[17:0]] <= ram_dout; ram_v[ram_a[17:0]] <= 1'b1; end
    end

    // Reference memory contents.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        int key;
        key = int'(a[17:0]);
        return ref_mem.exists(key) ? ref_mem[key] : init_byte(a[17:0]);
    endfunction

    typedef struct {
        bit          store;
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_if_exp = '0;

    logic [31:0] tr_a  [64];
    logic        tr_wr [64];
    logic [7:0]  tr_d  [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            tr_a[cyc % 64]  = ram_a;
            tr_wr[cyc % 64] = ram_wr;
            tr_d[cyc % 64]  = ram_dout;
            if (if_done && rdy) begin
                if (if_q.size() == 0) chk("if_spurious_done", 32'd1, 32'd0);
                else begin
                    e = if_q.pop_front();
                    chk("if_inst", if_inst, e.data);
                    last_if_exp = e.data;
                end
            end
            if (mem_done && rdy) begin
                if (mem_q.size() == 0) chk("mem_spurious_done", 32'd1, 32'd0);
                else begin
                    e = mem_q.pop_front();
                    if (e.store) begin
                        for (int k = 0; k < e.n; k++) begin
                            logic [31:0] t;
                            t = e.addr + k;
                            chk("store_byte", {24'h0, ram[t[17:0]]}, {24'h0, e.data[8*k +: 8]});
                        end
                    end else begin
                        chk("mem_rdata", mem_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_a = a; poke_d = d;
        ref_mem[int'(a)] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic if_issue(input logic [31:0] a);
        exp_t e;
        e.store = 1'b0; e.addr = a; e.n = 4; e.data = '0;
        for (int k = 0; k < 4; k++) e.data |= {24'h0, ref_byte(a + k)} << (8 * k);
        if_q.push_back(e);
        if_addr = a; if_req = 1'b1;
    endtask

    task automatic mem_issue(input bit we, input logic [1:0] len, input logic [31:0] a,
                             input logic [31:0] wd);
        exp_t e;
        logic [31:0] t;
        e.store = we; e.addr = a; e.data = '0;
        e.n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        for (int k = 0; k < e.n; k++) begin
            t = a + k;
            if (we) ref_mem[int'(t[17:0])] = wd[8*k +: 8];
            else    e.data |= {24'h0, ref_byte(t)} << (8 * k);
        end
        if (we) e.data = wd;
        mem_q.push_back(e);
        mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    endtask

    // Waits (bounded) for a done pulse, returns its cycle and drops the request.
    task automatic wait_done(input bit is_mem, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (is_mem ? (mem_done && rdy) : (if_done && rdy)) begin at = cyc; break; end
        end
        if (at < 0) chk(is_mem ? "mem_done_timeout" : "if_done_timeout", 32'd1, 32'd0);
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
    endtask

    int c0, at_m, at_i, nwr, threads_done;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_if_done", {31'h0, if_done}, 0);  chk("rst_mem_done", {31'h0, mem_done}, 0);
        chk("rst_if_inst", if_inst, 0);           chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_ram_a", ram_a, 0);               chk("rst_ram_wr", {31'h0, ram_wr}, 0);
        chk("rst_ram_dout", {24'h0, ram_dout}, 0);
        @(posedge clk); #1 rst = 1'b0;

        poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h10); poke(18'h103, 8'h00);
        poke(18'h200, 8'hFF);

        // Fetch at 0x100
        @(posedge clk); #1;
        if_issue(32'h100); if_q[if_q.size()-1].data = 32'h00100513; c0 = cyc;
        wait_done(1'b0, 20, at_i); #1;
        chk("fetch_lat", at_i - c0, 6);
        for (int k = 1; k <= 4; k++) begin
            chk("fetch_addr", tr_a[(c0 + k) % 64], 32'h100 + k - 1);
            chk("fetch_no_wr", {31'h0, tr_wr[(c0 + k) % 64]}, 0);
        end

        // Simultaneous requests: MEM wins, IF follows with zero bubbles
        @(posedge clk); #1;
        if_issue(32'h100); if_q[if_q.size()-1].data = 32'h00100513;
        mem_issue(1'b0, 2'd0, 32'h200, 32'h0); mem_q[mem_q.size()-1].data = 32'h000000FF;
        c0 = cyc;
        fork
            wait_done(1'b1, 20, at_m);
            wait_done(1'b0, 20, at_i);
        join
        chk("prio_mem_lat", at_m - c0, 3);
        chk("prio_if_lat", at_i - c0, 9);

        // Store crossing 0x1FFFF -> 0x20000
        @(posedge clk); #1;
        mem_issue(1'b1, 2'd1, 32'h1FFFF, 32'hAABBCCDD); c0 = cyc;
        wait_done(1'b1, 20, at_m); #1;
        chk("store_lat", at_m - c0, 3);
        chk("store_wr1", {31'h0, tr_wr[(c0 + 1) % 64]}, 1);
        chk("store_a1", tr_a[(c0 + 1) % 64], 32'h1FFFF);
        chk("store_d1", {24'h0, tr_d[(c0 + 1) % 64]}, 32'hDD);
        chk("store_wr2", {31'h0, tr_wr[(c0 + 2) % 64]}, 1);
        chk("store_a2", tr_a[(c0 + 2) % 64], 32'h20000);
        chk("store_d2", {24'h0, tr_d[(c0 + 2) % 64]}, 32'hCC);
        chk("store_wr3", {31'h0, tr_wr[(c0 + 3) % 64]}, 0);

        // 4-byte load with rdy low in cycles 3..5
        @(posedge clk); #1;
        mem_issue(1'b0, 2'd3, 32'h10100, 32'h0); c0 = cyc;
        fork
            wait_done(1'b1, 30, at_m);
            begin
                repeat (3) @(posedge clk); #1 rdy = 1'b0;
                repeat (3) @(posedge clk); #1 rdy = 1'b1;
            end
        join
        #1;
        chk("stall_lat_le10", {31'h0, (at_m - c0) <= 10}, 1);
        nwr = 0;
        for (int k = 0; k <= at_m - c0; k++) nwr += int'(tr_wr[(c0 + k) % 64]);
        chk("stall_no_wr", nwr, 0);

        // Load wrapping past 0xFFFFFFFF
        @(posedge clk); #1;
        mem_issue(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
        wait_done(1'b1, 20, at_m);

        // Flush during a fetch
        @(posedge clk); #1;
`ifdef MEM_ARB_FLUSH_EN
        if_addr = 32'h300; if_req = 1'b1; c0 = cyc;
        repeat (3) @(posedge clk); #1 begin if_flush = 1'b1; if_req = 1'b0; end
        @(posedge clk); #1 if_flush = 1'b0;
        nwr = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); nwr += int'(if_done); end
        chk("flush_no_done", nwr, 0);
        chk("flush_if_inst", if_inst, last_if_exp);
`else
        if_issue(32'h300); c0 = cyc;
        fork
            wait_done(1'b0, 20, at_i);
            begin
                repeat (3) @(posedge clk); #1 if_flush = 1'b1;
                @(posedge clk); #1 if_flush = 1'b0;
            end
        join
        chk("flush_ignored_lat", at_i - c0, 6);
`endif

        // Reset in cycle 2 of a 4-byte store
        @(posedge clk); #1;
        mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h30000; mem_wdata = 32'h11223344;
        mem_req = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("arst_ram_wr", {31'h0, ram_wr}, 0);   chk("arst_ram_a", ram_a, 0);
        chk("arst_ram_dout", {24'h0, ram_dout}, 0);
        chk("arst_mem_done", {31'h0, mem_done}, 0); chk("arst_if_done", {31'h0, if_done}, 0);
        chk("arst_if_inst", if_inst, 0);          chk("arst_mem_rdata", mem_rdata, 0);
        mem_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        nwr = 0;
        for (int k = 0; k < 6; k++) begin @(negedge clk); nwr += int'(mem_done); end
        chk("arst_no_done", nwr, 0);
        chk("arst_byte0_written", {31'h0, ram_v[18'h30000]}, 1);
        chk("arst_byte1_untouched", {31'h0, ram_v[18'h30001]}, 0);
        @(posedge clk); #1;
        mem_issue(1'b0, 2'd0, 32'h10, 32'h0); c0 = cyc;
        wait_done(1'b1, 20, at_m);
        chk("post_rst_lat", at_m - c0, 3);

        // Random traffic with random stalls
        threads_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int at;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
`ifndef MEM_ARB_FLUSH_EN
                    if_flush = ($urandom_range(0, 3) == 0);
`endif
                    if_issue({20'h0, 12'($urandom)});
                    wait_done(1'b0, 200, at);
                end
                threads_done++;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int at;
                    bit we;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    we = $urandom_range(0, 1) == 1;
                    if (we || $urandom_range(0, 1) == 1) a = 32'h10000 + $urandom_range(0, 16'hFFF0);
                    else a = {20'h0, 12'($urandom)};
                    mem_issue(we, 2'($urandom), a, $urandom);
                    wait_done(1'b1, 200, at);
                end
                threads_done++;
            end
            begin
                while (threads_done < 2) begin
                    @(posedge clk); #1 rdy = ($urandom_range(0, 7) != 0);
                end
                rdy = 1'b1;
            end
        join
        if_flush = 1'b0;
        repeat (10) @(posedge clk);
        chk("if_q_drained", if_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
